// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register addresses,
// source indices and the service state encoding.
package intc_pkg;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam int INT_VBLANK = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } intc_state_e;

endpackage

// File: rtl/intc_priority_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module intc_priority_enc #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller with IF (FF0F) / IE (FFFF) registers, priority vectoring
// and per-source acknowledge. Optional wake output under INTC_HALT_WAKE_EN.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int          NUM_INT       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               clock,
  input  logic               reset,
`ifdef INTC_HALT_WAKE_EN
  output logic               wake,
`endif
  input  logic [NUM_INT-1:0] src_req,
  output logic [NUM_INT-1:0] src_ack,
  input  logic [15:0]        A,
  input  logic [7:0]         Di,
  output logic [7:0]         Do,
  input  logic               wr_n,
  input  logic               rd_n,
  input  logic               cs,
  output logic               cpu_irq,
  output logic [15:0]        cpu_vector,
  input  logic               cpu_ack
);

  localparam int SEL_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
  localparam logic [NUM_INT-1:0] ONE_HOT_LSB = NUM_INT'(1);

  intc_state_e        state_q, state_d;
  logic [NUM_INT-1:0] reqPrev_q;
  logic [NUM_INT-1:0] intFlag_q, intFlag_d;
  logic [NUM_INT-1:0] intEnable_q, intEnable_d;
  logic [7:0]         regOut_q, regOut_d;
  logic [15:0]        vector_q, vector_d;
  logic [SEL_W-1:0]   svc_q, svc_d;

  logic [NUM_INT-1:0] reqEdges;
  logic [NUM_INT-1:0] pend;
  logic [NUM_INT-1:0] svcClear;
  logic [SEL_W-1:0]   sel;
  logic               selValid;
  logic               wrStrobe, rdStrobe, wrIf, wrIe;
  logic               unusedDi;

  assign reqEdges = src_req & ~reqPrev_q;
  assign pend     = intFlag_q & intEnable_q;
  assign wrStrobe = cs && !wr_n;
  assign rdStrobe = cs && !rd_n && wr_n;
  assign wrIf     = wrStrobe && (A == ADDR_IF);
  assign wrIe     = wrStrobe && (A == ADDR_IE);
  assign unusedDi = ^Di[7:NUM_INT];

  intc_priority_enc #(
    .N     (NUM_INT),
    .IDX_W (SEL_W)
  ) u_prio (
    .req_i   (pend),
    .idx_o   (sel),
    .valid_o (selValid)
  );

  // A service is taken only while something is still pending, so an ack that
  // coincides with software clearing pend just falls back to IDLE.
  always_comb begin
    state_d  = state_q;
    svc_d    = svc_q;
    svcClear = '0;
    case (state_q)
      IDLE: if (selValid) state_d = PEND;
      PEND: begin
        if (!selValid) begin
          state_d = IDLE;
        end else if (cpu_ack) begin
          svc_d    = sel;
          svcClear = ONE_HOT_LSB << sel;
          state_d  = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Layering order gives: edge set > service clear > CPU write.
  always_comb begin
    intFlag_d = intFlag_q;
    if (wrIf) intFlag_d = Di[NUM_INT-1:0];
    intFlag_d = (intFlag_d & ~svcClear) | reqEdges;
  end

  always_comb begin
    intEnable_d = intEnable_q;
    if (wrIe) intEnable_d = Di[NUM_INT-1:0];
  end

  always_comb begin
    regOut_d = regOut_q;
    if (rdStrobe) begin
      if (A == ADDR_IF)      regOut_d = {{(8-NUM_INT){1'b1}}, intFlag_q};
      else if (A == ADDR_IE) regOut_d = {{(8-NUM_INT){1'b0}}, intEnable_q};
    end
  end

  always_comb begin
    vector_d = vector_q;
    if (selValid) vector_d = VECTOR_BASE + (16'(sel) * 16'(VECTOR_STRIDE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      reqPrev_q   <= '0;
      intFlag_q   <= '0;
      intEnable_q <= '0;
      regOut_q    <= '0;
      vector_q    <= VECTOR_BASE;
      svc_q       <= '0;
    end else begin
      state_q     <= state_d;
      reqPrev_q   <= src_req;
      intFlag_q   <= intFlag_d;
      intEnable_q <= intEnable_d;
      regOut_q    <= regOut_d;
      vector_q    <= vector_d;
      svc_q       <= svc_d;
    end
  end

  assign cpu_irq    = (state_q == PEND);
  assign cpu_vector = vector_q;
  assign src_ack    = (state_q == ACK) ? (ONE_HOT_LSB << svc_q) : '0;
  assign Do         = cs ? regOut_q : 8'bz;

`ifdef INTC_HALT_WAKE_EN
  assign wake = |pend;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; also exercises the
// wake output when built with INTC_HALT_WAKE_EN.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  src_req;
  logic [4:0]  src_ack;
  logic [15:0] A;
  logic [7:0]  Di;
  logic [7:0]  Do;
  logic        wr_n, rd_n, cs;
  logic        cpu_irq;
  logic [15:0] cpu_vector;
  logic        cpu_ack;
`ifdef INTC_HALT_WAKE_EN
  logic        wake;
`endif

  int testsRun  = 0;
  int failCount = 0;
  logic [7:0]  rdData;
  logic [31:0] zExp;

  always #5 clock = ~clock;

  interrupt_controller dut (
    .clock      (clock),
    .reset      (reset),
`ifdef INTC_HALT_WAKE_EN
    .wake       (wake),
`endif
    .src_req    (src_req),
    .src_ack    (src_ack),
    .A          (A),
    .Di         (Di),
    .Do         (Do),
    .wr_n       (wr_n),
    .rd_n       (rd_n),
    .cs         (cs),
    .cpu_irq    (cpu_irq),
    .cpu_vector (cpu_vector),
    .cpu_ack    (cpu_ack)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] req, input logic ack);
    src_req = req;
    cpu_ack = ack;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
    A = addr; Di = data; cs = 1'b1; wr_n = 1'b0;
    tick();
    wr_n = 1'b1; cs = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] addr, output logic [7:0] data);
    A = addr; cs = 1'b1; rd_n = 1'b0;
    tick();
    data = Do;
    rd_n = 1'b1; cs = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_req = '0; cpu_ack = 1'b0;
    A = '0; Di = '0; wr_n = 1'b1; rd_n = 1'b1; cs = 1'b0;
    zExp = {24'h0, 8'hzz};
    tick(); tick();
    checkOutput("rst_irq", {31'b0, cpu_irq}, 32'd0);
    checkOutput("rst_vec", {16'b0, cpu_vector}, 32'h0040);
    checkOutput("rst_ack", {27'b0, src_ack}, 32'd0);
    reset = 1'b0;
    busRead(16'hFF0F, rdData);
    checkOutput("rst_if", {24'b0, rdData}, 32'hE0);
    busRead(16'hFFFF, rdData);
    checkOutput("rst_ie", {24'b0, rdData}, 32'h00);

    // Timer request held high, serviced once
    busWrite(16'hFFFF, 8'h04);
    applyStimulus(5'b00100, 1'b0);
    checkOutput("t1_irq_lat", {31'b0, cpu_irq}, 32'd0);
    applyStimulus(5'b00100, 1'b0);
    checkOutput("t1_irq", {31'b0, cpu_irq}, 32'd1);
    checkOutput("t1_vec", {16'b0, cpu_vector}, 32'h0050);
    applyStimulus(5'b00100, 1'b1);
    checkOutput("t1_srcack", {27'b0, src_ack}, 32'b00100);
    checkOutput("t1_irq_ack", {31'b0, cpu_irq}, 32'd0);
    applyStimulus(5'b00100, 1'b0);
    checkOutput("t1_srcack_off", {27'b0, src_ack}, 32'd0);
    busRead(16'hFF0F, rdData);
    checkOutput("t1_if_clear", {24'b0, rdData}, 32'hE0);
    applyStimulus(5'b00100, 1'b0);
    checkOutput("t1_no_reset", {31'b0, cpu_irq}, 32'd0);
    src_req = '0;

    // Preemption by a higher-priority source
    busWrite(16'hFFFF, 8'h1F);
    applyStimulus(5'b10000, 1'b0);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("t2_irq", {31'b0, cpu_irq}, 32'd1);
    checkOutput("t2_vec_joy", {16'b0, cpu_vector}, 32'h0060);
    applyStimulus(5'b00001, 1'b0);
    checkOutput("t2_vec_hold", {16'b0, cpu_vector}, 32'h0060);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("t2_vec_vbl", {16'b0, cpu_vector}, 32'h0040);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("t2_ack_vbl", {27'b0, src_ack}, 32'b00001);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("t2_ack_off", {27'b0, src_ack}, 32'd0);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("t2_irq2", {31'b0, cpu_irq}, 32'd1);
    checkOutput("t2_vec2", {16'b0, cpu_vector}, 32'h0060);
    busRead(16'hFF0F, rdData);
    checkOutput("t2_if", {24'b0, rdData}, 32'hF0);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("t2_ack_joy", {27'b0, src_ack}, 32'b10000);
    tick();

    // Register reads, latency and tristate
    busWrite(16'hFFFF, 8'h00);
    busWrite(16'hFF0F, 8'h05);
    busRead(16'hFF0F, rdData);
    checkOutput("t3_rd_if", {24'b0, rdData}, 32'hE5);
    busWrite(16'hFFFF, 8'h1F);
    A = 16'hFFFF; cs = 1'b1; rd_n = 1'b0;
    #1;
    checkOutput("t3_rd_lat", {24'b0, Do}, 32'hE5);
    tick();
    checkOutput("t3_rd_ie", {24'b0, Do}, 32'h1F);
    rd_n = 1'b1; cs = 1'b0;
    #1;
    checkOutput("t3_do_z", {24'b0, Do}, zExp);
    busWrite(16'hFFFF, 8'h00);
    tick();
    busWrite(16'hFF0F, 8'h00);

    // Edge set beats a clearing write; IE cleared while pending
    src_req = 5'b00010;
    busWrite(16'hFF0F, 8'h00);
    busRead(16'hFF0F, rdData);
    checkOutput("t4_edge_wins", {24'b0, rdData}, 32'hE2);
    busWrite(16'hFFFF, 8'h1F);
    tick();
    checkOutput("t4_irq", {31'b0, cpu_irq}, 32'd1);
    checkOutput("t4_vec", {16'b0, cpu_vector}, 32'h0048);
    busWrite(16'hFFFF, 8'h00);
    checkOutput("t4_irq_hold", {31'b0, cpu_irq}, 32'd1);
    applyStimulus(5'b00010, 1'b1);
    checkOutput("t4_drop_ack", {27'b0, src_ack}, 32'd0);
    checkOutput("t4_irq_drop", {31'b0, cpu_irq}, 32'd0);
    applyStimulus(5'b00010, 1'b1);
    checkOutput("t4_idle_ack", {27'b0, src_ack}, 32'd0);
    busRead(16'hFF0F, rdData);
    checkOutput("t4_if_kept", {24'b0, rdData}, 32'hE2);

    // Edge set beats service clear; service clear beats writing a 1
    src_req = 5'b00000;
    busWrite(16'hFFFF, 8'h1F);
    tick();
    applyStimulus(5'b00010, 1'b1);
    checkOutput("t4_svc_edge", {27'b0, src_ack}, 32'b00010);
    tick();
    busRead(16'hFF0F, rdData);
    checkOutput("t4_if_reset", {24'b0, rdData}, 32'hE2);
    A = 16'hFF0F; Di = 8'h02; cs = 1'b1; wr_n = 1'b0;
    applyStimulus(5'b00010, 1'b1);
    wr_n = 1'b1; cs = 1'b0;
    checkOutput("t4_svc_wr", {27'b0, src_ack}, 32'b00010);
    tick();
    busRead(16'hFF0F, rdData);
    checkOutput("t4_clear_wins", {24'b0, rdData}, 32'hE0);
    src_req = 5'b00000;

    // Reset while in ACK
    applyStimulus(5'b01000, 1'b0);
    applyStimulus(5'b01000, 1'b0);
    applyStimulus(5'b01000, 1'b1);
    checkOutput("t5_in_ack", {27'b0, src_ack}, 32'b01000);
    reset = 1'b1; src_req = '0;
    tick();
    reset = 1'b0;
    checkOutput("t5_ack", {27'b0, src_ack}, 32'd0);
    checkOutput("t5_irq", {31'b0, cpu_irq}, 32'd0);
    checkOutput("t5_vec", {16'b0, cpu_vector}, 32'h0040);
    busRead(16'hFF0F, rdData);
    checkOutput("t5_if", {24'b0, rdData}, 32'hE0);
    busRead(16'hFFFF, rdData);
    checkOutput("t5_ie", {24'b0, rdData}, 32'h00);

`ifdef INTC_HALT_WAKE_EN
    busWrite(16'hFFFF, 8'h08);
    checkOutput("w_idle", {31'b0, wake}, 32'd0);
    applyStimulus(5'b01000, 1'b0);
    checkOutput("w_set", {31'b0, wake}, 32'd1);
    checkOutput("w_no_irq", {31'b0, cpu_irq}, 32'd0);
    applyStimulus(5'b00000, 1'b0);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("w_clear", {31'b0, wake}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
